// File: rtl/exec_rr_scheduler.sv
// ----------------------------------------------------------------------------
// exec_rr_scheduler
//
// This module shares one multi-cycle execution unit among NREQ requesters. It
// uses round-robin arbitration. For each operation it sends a one-cycle start
// pulse and waits for the unit's done. It reports the result to the owner as
// either ack (the unit completed) or err (the timeout expired). It also keeps a
// wrapping count of completed operations.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : asynchronous, active-high reset
//   enable  : allows a new arbitration; an operation already in flight still
//             runs to completion
//   req     : request level, one bit per requester
//   done    : completion from the execution unit; only sampled in WAIT
//   start   : one-cycle pulse to the execution unit
//   grant   : one-hot owner of the unit, held from START through DONE/ABORT
//   ack     : one-cycle completion pulse to the owner
//   err     : one-cycle timeout pulse to the owner
//   busy    : high whenever the scheduler is not idle
//   count   : number of completed operations, wraps modulo 2^CNT_W
//
// Every output is a register. The output-comb process computes the value
// each output takes in the next cycle.
// ----------------------------------------------------------------------------
module exec_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 16,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic             start,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  ack,
    output logic [NREQ-1:0]  err,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [PTR_W:0]   NREQ_W  = (PTR_W+1)'(NREQ);
    localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(NREQ - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] win_reg, win_next;
    logic [TO_W-1:0]  timer_reg, timer_next;

    logic             start_next;
    logic [NREQ-1:0]  grant_next, ack_next, err_next;
    logic             busy_next;
    logic [CNT_W-1:0] count_next;

    logic [PTR_W-1:0] cand_idx [NREQ];
    logic [NREQ-1:0]  cand_hit;
    logic [PTR_W-1:0] pick;
    logic             pick_valid;
    logic [NREQ-1:0]  pick_onehot;
    logic [NREQ-1:0]  win_onehot;
    logic [PTR_W-1:0] win_inc;
    logic             timeout_hit;

    // Candidate gi is requester (ptr + gi) mod NREQ. Candidate 0 has the
    // highest priority, which makes the search start at ptr and go upward.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [PTR_W:0] sum;
            assign sum           = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= NREQ_W) ? PTR_W'(sum - NREQ_W) : sum[PTR_W-1:0];
            assign cand_hit[gi]  = req[cand_idx[gi]];
            assign pick_onehot[gi] = (pick == PTR_W'(gi));
            assign win_onehot[gi]  = (win_reg == PTR_W'(gi));
        end
    endgenerate

    // The loop counts down, so the lowest-offset requesting candidate is
    // written last and wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                pick       = cand_idx[i];
                pick_valid = 1'b1;
            end
        end
    end

    assign win_inc = (win_reg == LAST_IX) ? '0 : win_reg + PTR_W'(1);

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = (timer_reg == TO_LAST);
        end
    endgenerate

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable && pick_valid) state_next = START;
            START:   state_next = WAIT;
            // If done and the timeout happen in the same cycle, done wins.
            WAIT: begin
                if (done)             state_next = DONE;
                else if (timeout_hit) state_next = ABORT;
            end
            DONE:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // --------------------------------------------- outputs (next-cycle values)
    always_comb begin
        start_next = 1'b0;
        grant_next = grant;
        ack_next   = '0;
        err_next   = '0;
        busy_next  = (state_next != IDLE);
        count_next = count;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        timer_next = timer_reg;
        case (state_reg)
            IDLE: begin
                if (state_next == START) begin
                    win_next   = pick;
                    grant_next = pick_onehot;
                    start_next = 1'b1;
                end
            end
            START: begin
                timer_next = '0;
            end
            WAIT: begin
                if (state_next == DONE) begin
                    ack_next   = win_onehot;
                    count_next = count + CNT_W'(1);
                end else if (state_next == ABORT) begin
                    err_next = win_onehot;
                end else begin
                    timer_next = timer_reg + TO_W'(1);
                end
            end
            DONE, ABORT: begin
                ptr_next   = win_inc;
                grant_next = '0;
            end
            default: begin
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start     <= 1'b0;
            grant     <= '0;
            ack       <= '0;
            err       <= '0;
            busy      <= 1'b0;
            count     <= '0;
            ptr_reg   <= '0;
            win_reg   <= '0;
            timer_reg <= '0;
        end else begin
            start     <= start_next;
            grant     <= grant_next;
            ack       <= ack_next;
            err       <= err_next;
            busy      <= busy_next;
            count     <= count_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            timer_reg <= timer_next;
        end
    end

endmodule

// File: tb/tb_exec_rr_scheduler.sv
// ----------------------------------------------------------------------------
// Self-checking bench for exec_rr_scheduler (NREQ=4, CNT_W=4, TIMEOUT=5).
// The reference model tracks the current owner and how many cycles have
// passed since it was granted. Directed scenarios pin the model to
// hand-computed values. A randomized phase then exercises the full behaviour
// against the model.
// ----------------------------------------------------------------------------
module tb_exec_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [NREQ-1:0]  req;
    logic             done;
    logic             start;
    logic [NREQ-1:0]  grant, ack, err;
    logic             busy;
    logic [CNT_W-1:0] count;

    int vectors     = 0;
    int miscompares = 0;
    int resp_mode   = 0;   // 0: done never driven, 1: fixed delay, 2: random delay
    int resp_delay  = 1;

    exec_rr_scheduler #(
        .NREQ(NREQ), .CNT_W(CNT_W), .TO_W(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .done(done),
        .start(start), .grant(grant), .ack(ack), .err(err),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ reference
    // owner = -1 means idle. age 0 is the start cycle and age k >= 1 is the
    // k-th cycle waiting on the unit. fin 1 marks an ack cycle, fin 2 an err
    // cycle.
    int               m_owner = -1;
    int               m_age   = 0;
    int               m_fin   = 0;
    int               m_ptr   = 0;
    logic [CNT_W-1:0] m_count = '0;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1; m_age <= 0; m_fin <= 0; m_ptr <= 0; m_count <= '0;
        end else if (m_fin != 0) begin
            m_owner <= -1; m_fin <= 0;
        end else if (m_owner >= 0) begin
            if (m_age == 0) begin
                m_age <= 1;
            end else if (done) begin
                m_fin   <= 1;
                m_count <= m_count + CNT_W'(1);
                m_ptr   <= (m_owner + 1) % NREQ;
            end else if (TIMEOUT != 0 && m_age == TIMEOUT) begin
                m_fin <= 2;
                m_ptr <= (m_owner + 1) % NREQ;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (enable && req != '0) begin
            m_owner <= rr_pick(req, m_ptr);
            m_age   <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: checks every output against the model on every cycle.
    always @(negedge clk) begin
        chk("start", 32'(start), 32'(m_owner >= 0 && m_age == 0 && m_fin == 0));
        chk("grant", 32'(grant), 32'(onehot(m_owner)));
        chk("ack",   32'(ack),   32'((m_fin == 1) ? onehot(m_owner) : '0));
        chk("err",   32'(err),   32'((m_fin == 2) ? onehot(m_owner) : '0));
        chk("busy",  32'(busy),  32'(m_owner >= 0));
        chk("count", 32'(count), 32'(m_count));
        if (ack != '0 || err != '0)
            $display("op end: owner %b %s count %0d", grant, (ack != '0) ? "ack" : "err", count);
    end

    // Completion responder: it drives done resp_delay edges after seeing start.
    initial begin
        done = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_mode != 0 && start) begin
                int d;
                d = (resp_mode == 2) ? int'($urandom_range(1, 7)) : resp_delay;
                repeat (d) @(posedge clk);
                #1 done = 1'b1;
                @(posedge clk);
                #1 done = 1'b0;
            end
        end
    end

    task automatic wait_start(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (start) return;
        end
        chk({name, "_start_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_end(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack != '0 || err != '0) return;
        end
        chk({name, "_end_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
    endtask

    logic [NREQ-1:0] exp_rot [5];
    int nstart;
    int nwait;

    initial begin
        rst = 1'b1; enable = 1'b0; req = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        #1 rst = 1'b0;

        // Single op: done comes 3 cycles after start.
        resp_mode = 1; resp_delay = 3;
        req = 4'b0001; enable = 1'b1;
        wait_start("single");
        chk("single_grant", 32'(grant), 32'h1);
        req = '0;
        wait_end("single");
        chk("single_ack",   32'(ack),   32'h1);
        chk("single_count", 32'(count), 32'd1);
        @(negedge clk);
        chk("single_busy_low", 32'(busy), 32'd0);

        // Rotation with every requester active, starting from ptr=0.
        pulse_reset();
        resp_delay = 2;
        exp_rot[0] = 4'b0001; exp_rot[1] = 4'b0010; exp_rot[2] = 4'b0100;
        exp_rot[3] = 4'b1000; exp_rot[4] = 4'b0001;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start("rot");
            chk($sformatf("rot_grant%0d", k), 32'(grant), 32'(exp_rot[k]));
        end
        req = '0;
        wait_end("rot");
        chk("rot_count", 32'(count), 32'd5);

        // Timeout: done never arrives. err appears 5 cycles after WAIT is entered.
        resp_mode = 0;
        @(negedge clk);
        req = 4'b0100;
        wait_start("to");
        chk("to_grant", 32'(grant), 32'h4);
        req = '0;
        nwait = 0;
        for (int i = 0; i < 20 && err == '0; i++) begin
            @(negedge clk);
            nwait++;
        end
        chk("to_err_cycle", 32'(nwait), 32'd6);
        chk("to_err",       32'(err),   32'h4);
        chk("to_count",     32'(count), 32'd5);
        resp_mode = 1; resp_delay = 1;
        @(negedge clk);
        req = 4'b1111;
        wait_start("after_to");
        chk("after_to_grant", 32'(grant), 32'h8);
        req = '0;
        wait_end("after_to");

        // done arrives in the same cycle as the last timer value: done wins.
        resp_delay = 5;
        req = 4'b0001;
        wait_start("tie");
        req = '0;
        wait_end("tie");
        chk("tie_ack",   32'(ack),   32'h1);
        chk("tie_err",   32'(err),   32'h0);
        chk("tie_count", 32'(count), 32'd7);

        // Async reset in WAIT while grant=0010.
        resp_mode = 0;
        @(negedge clk);
        req = 4'b0010;
        wait_start("rst");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_start", 32'(start), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_busy",  32'(busy),  32'd0);
        chk("arst_count", 32'(count), 32'd0);
        resp_mode = 1; resp_delay = 1;
        @(negedge clk); #1 rst = 1'b0;
        wait_start("regrant");
        chk("regrant_grant", 32'(grant), 32'h2);
        req = '0;
        wait_end("regrant");

        // Enable gating.
        resp_delay = 2;
        enable = 1'b0; req = 4'b0011;
        nstart = 0;
        repeat (20) begin @(negedge clk); if (start) nstart++; end
        chk("disabled_starts", 32'(nstart), 32'd0);
        enable = 1'b1;
        wait_start("en");
        chk("en_grant", 32'(grant), 32'h1);
        enable = 1'b0;
        wait_end("en");
        chk("en_ack", 32'(ack), 32'h1);
        nstart = 0;
        repeat (10) begin @(negedge clk); if (start) nstart++; end
        chk("en_off_starts", 32'(nstart), 32'd0);
        enable = 1'b1;
        wait_start("en2");
        chk("en2_grant", 32'(grant), 32'h2);
        req = '0;
        wait_end("en2");

        // Randomized traffic, with occasional asynchronous resets.
        resp_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 5) == 0) req = NREQ'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            if (i % 700 == 350) begin
                #3 rst = 1'b1;
                @(negedge clk); #1 rst = 1'b0;
            end
        end
        req = '0; enable = 1'b1; resp_mode = 0;
        repeat (20) @(negedge clk);

        // Counter wrap: 17 completions on a 4-bit counter leave count=1.
        pulse_reset();
        resp_mode = 1; resp_delay = 1;
        req = 4'b1111;
        for (int k = 0; k < 17; k++) wait_start("wrap");
        req = '0;
        wait_end("wrap");
        chk("wrap_count", 32'(count), 32'd1);
        resp_mode = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
